// File: rtl/cfg_master.sv
// cfg_master: initiator for the configuration-register message bus.
// Takes one host command at a time, issues it to the register chain, waits
// for the response from the addressed register (or times out), and returns
// {err, wr, data} to the host.
//
// Messages are {addr, wr, payload}: addr in the MSBs, wr at bit PAYLOAD_SIZE,
// payload in the LSBs.
//
// Ports:
//   clk_i, reset_i           clock, synchronous active-high reset
//   cmd_val_i/cmd_rdy_o      host command handshake, cmd_msg_i
//   req_val_o/req_rdy_i      request to the chain, req_msg_o
//   rsp_val_i/rsp_rdy_o      response from the chain, rsp_msg_i
//   resp_val_o/resp_rdy_i    result to the host, resp_msg_o = {err, wr, data}
module cfg_master #(
  parameter int ADDR_SIZE    = 4,
  parameter int PAYLOAD_SIZE = 8,
  parameter int TIMEOUT      = 15
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               cmd_val_i,
  output logic                               cmd_rdy_o,
  input  logic [ADDR_SIZE+PAYLOAD_SIZE:0]    cmd_msg_i,
  output logic                               req_val_o,
  input  logic                               req_rdy_i,
  output logic [ADDR_SIZE+PAYLOAD_SIZE:0]    req_msg_o,
  input  logic                               rsp_val_i,
  output logic                               rsp_rdy_o,
  input  logic [ADDR_SIZE+PAYLOAD_SIZE:0]    rsp_msg_i,
  output logic                               resp_val_o,
  input  logic                               resp_rdy_i,
  output logic [PAYLOAD_SIZE+1:0]            resp_msg_o
);

  localparam int M  = ADDR_SIZE + PAYLOAD_SIZE + 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REPLY} state_e;

  state_e                  state_q, state_d;
  logic [M-1:0]            cur_q;
  logic [CW-1:0]           cnt_q;
  logic                    err_q;
  logic [PAYLOAD_SIZE-1:0] data_q;

  logic [ADDR_SIZE-1:0]    cur_addr, rsp_addr;
  logic                    cur_wr;
  logic                    rsp_match;
  logic                    timed_out;

  assign cur_addr  = cur_q[M-1 -: ADDR_SIZE];
  assign cur_wr    = cur_q[PAYLOAD_SIZE];
  assign rsp_addr  = rsp_msg_i[M-1 -: ADDR_SIZE];
  assign rsp_match = (state_q == WAIT) && rsp_val_i && (rsp_addr == cur_addr);
  // Timeout fires only in the last counted cycle and only without a match.
  assign timed_out = (state_q == WAIT) && !rsp_match && (cnt_q == CNT_LAST);

  // The echoed wr bit of a response carries no information we need.
  logic rsp_wr_unused;
  assign rsp_wr_unused = rsp_msg_i[PAYLOAD_SIZE];

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_val_i)              state_d = ISSUE;
      ISSUE:   if (req_rdy_i)              state_d = WAIT;
      WAIT:    if (rsp_match || timed_out) state_d = REPLY;
      REPLY:   if (resp_rdy_i)             state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  // Outputs: decoded from state and registered transaction fields only.
  always_comb begin
    cmd_rdy_o  = (state_q == IDLE);
    req_val_o  = (state_q == ISSUE);
    rsp_rdy_o  = (state_q == WAIT);
    resp_val_o = (state_q == REPLY);
    req_msg_o  = '0;
    resp_msg_o = '0;
    if (state_q == ISSUE)
      // Reads carry a zero payload on the bus.
      req_msg_o = {cur_addr, cur_wr, cur_wr ? cur_q[PAYLOAD_SIZE-1:0] : {PAYLOAD_SIZE{1'b0}}};
    if (state_q == REPLY)
      resp_msg_o = {err_q, cur_wr, data_q};
  end

  // Transaction datapath
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cur_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      data_q <= '0;
    end else begin
      unique case (state_q)
        IDLE:  if (cmd_val_i) cur_q <= cmd_msg_i;
        ISSUE: if (req_rdy_i) cnt_q <= '0;
        WAIT: begin
          if (rsp_match) begin
            err_q  <= 1'b0;
            data_q <= rsp_msg_i[PAYLOAD_SIZE-1:0];
          end else if (timed_out) begin
            err_q  <= 1'b1;
            data_q <= '0;
          end
          // Saturating count; non-matching responses do not stop it.
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_master.sv
// Randomized self-checking bench for cfg_master. The bench plays host and
// register chain; expectations come from a transaction-level model: the
// first matching response inside the TIMEOUT window wins, otherwise err.
module tb_cfg_master;

  localparam int AW = 4;
  localparam int PW = 8;
  localparam int TO = 15;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              cmd_val_i, cmd_rdy_o;
  logic [AW+PW:0]    cmd_msg_i;
  logic              req_val_o, req_rdy_i;
  logic [AW+PW:0]    req_msg_o;
  logic              rsp_val_i, rsp_rdy_o;
  logic [AW+PW:0]    rsp_msg_i;
  logic              resp_val_o, resp_rdy_i;
  logic [PW+1:0]     resp_msg_o;

  int checks = 0;
  int failures = 0;

  cfg_master #(.ADDR_SIZE(AW), .PAYLOAD_SIZE(PW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .cmd_val_i(cmd_val_i), .cmd_rdy_o(cmd_rdy_o), .cmd_msg_i(cmd_msg_i),
    .req_val_o(req_val_o), .req_rdy_i(req_rdy_i), .req_msg_o(req_msg_o),
    .rsp_val_i(rsp_val_i), .rsp_rdy_o(rsp_rdy_o), .rsp_msg_i(rsp_msg_i),
    .resp_val_o(resp_val_o), .resp_rdy_i(resp_rdy_i), .resp_msg_o(resp_msg_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".cmd_rdy"},  32'(cmd_rdy_o),  32'd1);
    chk({tag, ".req_val"},  32'(req_val_o),  32'd0);
    chk({tag, ".rsp_rdy"},  32'(rsp_rdy_o),  32'd0);
    chk({tag, ".resp_val"}, 32'(resp_val_o), 32'd0);
    chk({tag, ".req_msg"},  32'(req_msg_o),  32'd0);
    chk({tag, ".resp_msg"}, 32'(resp_msg_o), 32'd0);
  endtask

  // One host transaction. match_k / junk_k: WAIT-cycle index at which the
  // chain presents the matching / a foreign-address response (out of range
  // or -1 means never). Called at a negedge with the DUT idle.
  task automatic txn(input logic [AW-1:0] a, input logic w, input logic [PW-1:0] p,
                     input logic [PW-1:0] rdata, input int rq_dly, input int rs_dly,
                     input int match_k, input int junk_k);
    logic [AW+PW:0] exp_req;
    logic [PW+1:0]  exp_resp;
    logic [AW-1:0]  junk_a;
    int             exp_wait;
    int             k;
    bit             hit;

    hit      = (match_k >= 0) && (match_k < TO);
    exp_wait = hit ? match_k + 1 : TO;
    exp_resp = hit ? {1'b0, w, rdata} : {1'b1, w, {PW{1'b0}}};
    exp_req  = {a, w, w ? p : {PW{1'b0}}};
    junk_a   = a ^ AW'($urandom_range(1, (1 << AW) - 1));

    // IDLE: accept command; a stale response here must be ignored.
    chk("idle.cmd_rdy", 32'(cmd_rdy_o), 32'd1);
    chk("idle.rsp_rdy", 32'(rsp_rdy_o), 32'd0);
    cmd_val_i = 1'b1;
    cmd_msg_i = {a, w, p};
    rsp_val_i = 1'b1;
    rsp_msg_i = {a, 1'b0, ~rdata};
    @(negedge clk_i);
    cmd_val_i = 1'b0;
    cmd_msg_i = '0;

    // ISSUE: request held stable under backpressure; stale responses ignored.
    for (int i = 0; i <= rq_dly; i++) begin
      chk("issue.req_val", 32'(req_val_o), 32'd1);
      chk("issue.req_msg", 32'(req_msg_o), 32'(exp_req));
      chk("issue.cmd_rdy", 32'(cmd_rdy_o), 32'd0);
      chk("issue.rsp_rdy", 32'(rsp_rdy_o), 32'd0);
      rsp_val_i = 1'($urandom_range(0, 1));
      req_rdy_i = (i == rq_dly);
      @(negedge clk_i);
    end
    req_rdy_i = 1'b0;

    // WAIT: chain plays its schedule until the DUT replies (bounded).
    k = 0;
    while (!resp_val_o && k < TO + 4) begin
      chk("wait.rsp_rdy", 32'(rsp_rdy_o), 32'd1);
      chk("wait.cmd_rdy", 32'(cmd_rdy_o), 32'd0);
      if (k == match_k) begin
        rsp_val_i = 1'b1; rsp_msg_i = {a, w, rdata};
      end else if (k == junk_k) begin
        rsp_val_i = 1'b1; rsp_msg_i = {junk_a, w, PW'($urandom)};
      end else begin
        rsp_val_i = 1'b0; rsp_msg_i = '0;
      end
      @(negedge clk_i);
      k++;
    end
    chk("wait.cycles", 32'(k), 32'(exp_wait));

    // REPLY: result held stable under backpressure; stale responses ignored.
    for (int i = 0; i <= rs_dly; i++) begin
      chk("reply.resp_val", 32'(resp_val_o), 32'd1);
      chk("reply.resp_msg", 32'(resp_msg_o), 32'(exp_resp));
      chk("reply.cmd_rdy",  32'(cmd_rdy_o),  32'd0);
      chk("reply.rsp_rdy",  32'(rsp_rdy_o),  32'd0);
      rsp_val_i  = 1'($urandom_range(0, 1));
      rsp_msg_i  = {a, 1'b0, ~rdata};
      resp_rdy_i = (i == rs_dly);
      @(negedge clk_i);
    end
    resp_rdy_i = 1'b0;
    rsp_val_i  = 1'b0;
    rsp_msg_i  = '0;
    // Next command may be accepted right away.
    chk("post.resp_val", 32'(resp_val_o), 32'd0);
    chk("post.cmd_rdy",  32'(cmd_rdy_o),  32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1; cmd_val_i = 1'b0; cmd_msg_i = '0; req_rdy_i = 1'b0;
    rsp_val_i = 1'b0; rsp_msg_i = '0; resp_rdy_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk_reset_vals("reset");
    reset_i = 1'b0;
    @(negedge clk_i);
    chk_reset_vals("idle");

    // Write with immediate echo: minimum latency.
    txn(4'h0, 1'b1, 8'h55, 8'h55, 0, 0, 0, -1);
    // Read of addr 5 returning A5; request payload forced to zero.
    txn(4'h5, 1'b0, 8'($urandom), 8'hA5, 0, 0, 0, -1);
    // Address filter: foreign response first, then the match.
    txn(4'h0, 1'b0, 8'h00, 8'h22, 0, 0, 1, 0);
    // Timeout with no responses.
    txn(4'h2, 1'b0, 8'h00, 8'h77, 0, 0, -1, -1);
    // Match in the last counted cycle beats the timeout.
    txn(4'h2, 1'b0, 8'h00, 8'h3C, 0, 0, TO - 1, 3);
    // Match one cycle too late: timeout.
    txn(4'h9, 1'b1, 8'hF0, 8'hF0, 0, 0, TO, 2);
    // Backpressure on both sides, then a back-to-back command.
    txn(4'hC, 1'b1, 8'h81, 8'h81, 4, 3, 2, -1);
    txn(4'h7, 1'b0, 8'h00, 8'h19, 0, 0, 0, -1);

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      int mk, jk;
      logic [PW-1:0] pay;
      logic wr;
      wr  = 1'($urandom_range(0, 1));
      pay = 8'($urandom);
      mk  = $urandom_range(0, TO + 2);
      jk  = $urandom_range(0, TO + 2);
      if (jk == mk) jk = -1;
      txn(4'($urandom), wr, pay, wr ? pay : 8'($urandom),
          $urandom_range(0, 3), $urandom_range(0, 3), mk, jk);
    end

    // Reset mid-WAIT: transaction abandoned, no host response.
    cmd_val_i = 1'b1; cmd_msg_i = {4'h3, 1'b0, 8'h00};
    @(negedge clk_i);
    cmd_val_i = 1'b0; req_rdy_i = 1'b1;
    @(negedge clk_i);
    req_rdy_i = 1'b0;
    @(negedge clk_i);
    chk("rstwait.rsp_rdy", 32'(rsp_rdy_o), 32'd1);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    chk_reset_vals("rstwait");
    rsp_val_i = 1'b1; rsp_msg_i = {4'h3, 1'b0, 8'hEE};
    for (int i = 0; i < TO + 4; i++) begin
      @(negedge clk_i);
      chk("rstwait.no_resp", 32'({resp_val_o, cmd_rdy_o, rsp_rdy_o}), 32'b010);
    end
    rsp_val_i = 1'b0;
    @(negedge clk_i);
    // The block is usable again after the abandoned transaction.
    txn(4'h3, 1'b0, 8'h00, 8'h5A, 1, 1, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
